// File: rtl/interrupt_sequencer.sv
// TCU step counter plus NMI/IRQ/reset entry sequencer for the CPU core.
// Optional: define INTERRUPT_SEQUENCER_NMI_HIJACK_EN to let an NMI hijack an IRQ/BRK entry.
module interrupt_sequencer #(
   parameter int unsigned TCU_WIDTH = 3,
   parameter int unsigned TCU_MAX   = 7
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_rdy,
   input  logic                 i_last_cycle,
   input  logic                 i_nmi_n,
   input  logic                 i_irq_n,
   input  logic                 i_flag_i,
   output logic [TCU_WIDTH-1:0] o_tcu,
   output logic                 o_sync,
   output logic                 o_interrupt,
   output logic [1:0]           o_vector_sel,
   output logic                 o_pc_hold,
   output logic                 o_b_flag,
   output logic                 o_write_inhibit
);

   typedef enum logic [0:0] {StRun, StEntry} seq_state_e;

   localparam logic [1:0] VecIrq   = 2'b00;
   localparam logic [1:0] VecNmi   = 2'b01;
   localparam logic [1:0] VecReset = 2'b10;

   seq_state_e           state_q, state_d;
   logic [TCU_WIDTH-1:0] tcu_q, tcu_d;
   logic [1:0]           vector_q, vector_d;
   logic                 reset_pending_q, reset_pending_d;
   logic                 nmi_pending_q, nmi_pending_d;
   logic                 nmi_prev_q;
   logic                 interrupt_q, interrupt_d;
   logic                 b_flag_q, b_flag_d;
   logic                 write_inhibit_q, write_inhibit_d;

   logic nmi_edge, irq_active, boundary, decision, take;
   logic reset_clr, nmi_clr, nmi_hijack, clr_step;

   always_comb begin
      nmi_edge   = nmi_prev_q & ~i_nmi_n;
      irq_active = ~i_irq_n & ~i_flag_i;
      boundary   = i_last_cycle || (tcu_q == TCU_WIDTH'(TCU_MAX));
      decision   = i_rdy && boundary;
      clr_step   = (state_q == StEntry) && i_rdy && (tcu_q == TCU_WIDTH'(1));
      reset_clr  = clr_step && (vector_q == VecReset);
      nmi_clr    = clr_step && (vector_q == VecNmi);
      nmi_hijack = 1'b0;
      // A source cleared in this same cycle must not re-trigger its own entry.
      take = (reset_pending_q & ~reset_clr) | (nmi_pending_q & ~nmi_clr) | irq_active;

      tcu_d           = tcu_q;
      state_d         = state_q;
      vector_d        = vector_q;
      reset_pending_d = reset_pending_q & ~reset_clr;

      if (i_rdy) begin
         tcu_d = boundary ? '0 : tcu_q + 1'b1;
      end

      if (decision) begin
         if (take) begin
            state_d = StEntry;
            if (reset_pending_q && !reset_clr) begin
               vector_d = VecReset;
            end else if (nmi_pending_q && !nmi_clr) begin
               vector_d = VecNmi;
            end else begin
               vector_d = VecIrq;
            end
         end else begin
            state_d  = StRun;
            vector_d = VecIrq;
         end
      end
`ifdef INTERRUPT_SEQUENCER_NMI_HIJACK_EN
      else if ((state_q == StEntry) && i_rdy && (vector_q == VecIrq) &&
               (tcu_q <= TCU_WIDTH'(4)) && (nmi_edge || nmi_pending_q)) begin
         vector_d   = VecNmi;
         nmi_hijack = 1'b1;
      end
`endif

      // A fresh edge outranks the service clear so it is not lost.
      if (nmi_hijack) begin
         nmi_pending_d = 1'b0;
      end else if (nmi_edge) begin
         nmi_pending_d = 1'b1;
      end else if (nmi_clr) begin
         nmi_pending_d = 1'b0;
      end else begin
         nmi_pending_d = nmi_pending_q;
      end

      interrupt_d     = (state_d == StEntry);
      b_flag_d        = (state_d == StRun);
      write_inhibit_d = (state_d == StEntry) && (vector_d == VecReset);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q         <= StEntry;
         tcu_q           <= '0;
         vector_q        <= VecReset;
         reset_pending_q <= 1'b1;
         nmi_pending_q   <= 1'b0;
         nmi_prev_q      <= 1'b1;
         interrupt_q     <= 1'b1;
         b_flag_q        <= 1'b0;
         write_inhibit_q <= 1'b1;
      end else begin
         state_q         <= state_d;
         tcu_q           <= tcu_d;
         vector_q        <= vector_d;
         reset_pending_q <= reset_pending_d;
         nmi_pending_q   <= nmi_pending_d;
         nmi_prev_q      <= i_nmi_n;
         interrupt_q     <= interrupt_d;
         b_flag_q        <= b_flag_d;
         write_inhibit_q <= write_inhibit_d;
      end
   end

   assign o_tcu           = tcu_q;
   assign o_sync          = (tcu_q == '0);
   assign o_interrupt     = interrupt_q;
   assign o_vector_sel    = vector_q;
   assign o_pc_hold       = (state_q == StEntry) && (tcu_q <= TCU_WIDTH'(1));
   assign o_b_flag        = b_flag_q;
   assign o_write_inhibit = write_inhibit_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer; observed vector is
// {tcu, sync, interrupt, vector_sel, pc_hold, b_flag, write_inhibit}.
module tb_interrupt_sequencer;

   logic       i_clk;
   logic       i_reset;
   logic       i_rdy;
   logic       i_last_cycle;
   logic       i_nmi_n;
   logic       i_irq_n;
   logic       i_flag_i;
   logic [2:0] o_tcu;
   logic       o_sync;
   logic       o_interrupt;
   logic [1:0] o_vector_sel;
   logic       o_pc_hold;
   logic       o_b_flag;
   logic       o_write_inhibit;

   int checks = 0;
   int errors = 0;

   localparam logic [9:0] Run0     = 10'b000_1_0_00_0_1_0;
   localparam logic [9:0] ResetVal = 10'b000_1_1_10_1_0_1;
   localparam logic [9:0] IrqT0    = 10'b000_1_1_00_1_0_0;
   localparam logic [9:0] NmiT0    = 10'b000_1_1_01_1_0_0;

   logic [9:0] obs;
   assign obs = {o_tcu, o_sync, o_interrupt, o_vector_sel, o_pc_hold, o_b_flag, o_write_inhibit};

   interrupt_sequencer #(
      .TCU_WIDTH (3),
      .TCU_MAX   (7)
   ) dut (
      .i_clk           (i_clk),
      .i_reset         (i_reset),
      .i_rdy           (i_rdy),
      .i_last_cycle    (i_last_cycle),
      .i_nmi_n         (i_nmi_n),
      .i_irq_n         (i_irq_n),
      .i_flag_i        (i_flag_i),
      .o_tcu           (o_tcu),
      .o_sync          (o_sync),
      .o_interrupt     (o_interrupt),
      .o_vector_sel    (o_vector_sel),
      .o_pc_hold       (o_pc_hold),
      .o_b_flag        (o_b_flag),
      .o_write_inhibit (o_write_inhibit)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic run_instr(input int n);
      for (int i = 0; i < n; i++) begin
         i_last_cycle = (i == n - 1);
         tick();
      end
      i_last_cycle = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] exp;
      i_reset = 1'b1;
      tick();
      tick();
      checks++;
      if (obs !== ResetVal) begin
         errors++; $display("FAIL reset_state obs=%b exp=%b", obs, ResetVal);
      end
      i_reset = 1'b0;
      for (int k = 0; k < 7; k++) begin
         exp = {3'(k), (k == 0), 1'b1, 2'b10, (k <= 1), 1'b0, 1'b1};
         checks++;
         if (obs !== exp) begin
            errors++; $display("FAIL reset_entry_t%0d obs=%b exp=%b", k, obs, exp);
         end
         i_last_cycle = (k == 6);
         tick();
      end
      i_last_cycle = 1'b0;
      checks++;
      if (obs !== Run0) begin
         errors++; $display("FAIL reset_to_run obs=%b exp=%b", obs, Run0);
      end
   endtask

   task automatic test_irq();
      i_irq_n = 1'b0; i_flag_i = 1'b0;
      run_instr(3);
      checks++;
      if (obs !== IrqT0) begin
         errors++; $display("FAIL irq_entry obs=%b exp=%b", obs, IrqT0);
      end
      i_irq_n = 1'b1;
      tick();
      checks++;
      if (obs !== 10'b001_0_1_00_1_0_0) begin
         errors++; $display("FAIL irq_t1_hold obs=%b exp=%b", obs, 10'b001_0_1_00_1_0_0);
      end
      tick();
      checks++;
      if (obs !== 10'b010_0_1_00_0_0_0) begin
         errors++; $display("FAIL irq_t2_nohold obs=%b exp=%b", obs, 10'b010_0_1_00_0_0_0);
      end
      run_instr(5);
      checks++;
      if (obs !== Run0) begin
         errors++; $display("FAIL irq_exit obs=%b exp=%b", obs, Run0);
      end
      i_irq_n = 1'b0; i_flag_i = 1'b1;
      run_instr(3);
      checks++;
      if (obs !== Run0) begin
         errors++; $display("FAIL irq_masked obs=%b exp=%b", obs, Run0);
      end
      i_irq_n = 1'b1;
   endtask

   task automatic test_nmi_level();
      i_nmi_n = 1'b0;
      run_instr(3);
      checks++;
      if (obs !== NmiT0) begin
         errors++; $display("FAIL nmi_entry obs=%b exp=%b", obs, NmiT0);
      end
      run_instr(7);
      checks++;
      if (obs !== Run0) begin
         errors++; $display("FAIL nmi_exit obs=%b exp=%b", obs, Run0);
      end
      run_instr(3);
      checks++;
      if (obs !== Run0) begin
         errors++; $display("FAIL nmi_no_retrigger_a obs=%b exp=%b", obs, Run0);
      end
      run_instr(7);
      checks++;
      if (obs !== Run0) begin
         errors++; $display("FAIL nmi_no_retrigger_b obs=%b exp=%b", obs, Run0);
      end
      i_nmi_n = 1'b1;
      run_instr(2);
   endtask

   task automatic test_nmi_chain();
      i_nmi_n = 1'b0;
      tick();
      i_nmi_n = 1'b1;
      run_instr(1);
      checks++;
      if (obs !== NmiT0) begin
         errors++; $display("FAIL chain_first_entry obs=%b exp=%b", obs, NmiT0);
      end
      tick();
      i_nmi_n = 1'b0;
      tick();
      checks++;
      if (obs !== 10'b010_0_1_01_0_0_0) begin
         errors++; $display("FAIL chain_t2 obs=%b exp=%b", obs, 10'b010_0_1_01_0_0_0);
      end
      run_instr(5);
      checks++;
      if (obs !== NmiT0) begin
         errors++; $display("FAIL chain_second_entry obs=%b exp=%b", obs, NmiT0);
      end
      run_instr(7);
      checks++;
      if (obs !== Run0) begin
         errors++; $display("FAIL chain_exit obs=%b exp=%b", obs, Run0);
      end
      i_nmi_n = 1'b1;
      run_instr(2);
   endtask

   task automatic test_stall();
      tick();
      tick();
      i_rdy = 1'b0;
      i_nmi_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (obs !== 10'b010_0_0_00_0_1_0) begin
            errors++; $display("FAIL stall_hold_%0d obs=%b exp=%b", k, obs, 10'b010_0_0_00_0_1_0);
         end
      end
      i_rdy = 1'b1;
      run_instr(1);
      checks++;
      if (obs !== NmiT0) begin
         errors++; $display("FAIL stall_nmi_entry obs=%b exp=%b", obs, NmiT0);
      end
      run_instr(7);
      checks++;
      if (obs !== Run0) begin
         errors++; $display("FAIL stall_exit obs=%b exp=%b", obs, Run0);
      end
      i_nmi_n = 1'b1;
      run_instr(2);
   endtask

   task automatic test_hijack();
      i_irq_n = 1'b0; i_flag_i = 1'b0;
      run_instr(2);
      i_irq_n = 1'b1; i_flag_i = 1'b1;
      tick();
      tick();
      checks++;
      if (obs !== 10'b010_0_1_00_0_0_0) begin
         errors++; $display("FAIL hijack_pre obs=%b exp=%b", obs, 10'b010_0_1_00_0_0_0);
      end
      i_nmi_n = 1'b0;
      tick();
`ifdef INTERRUPT_SEQUENCER_NMI_HIJACK_EN
      checks++;
      if (obs !== 10'b011_0_1_01_0_0_0) begin
         errors++; $display("FAIL hijack_switch obs=%b exp=%b", obs, 10'b011_0_1_01_0_0_0);
      end
      run_instr(4);
      checks++;
      if (obs !== Run0) begin
         errors++; $display("FAIL hijack_no_chain obs=%b exp=%b", obs, Run0);
      end
`else
      checks++;
      if (obs !== 10'b011_0_1_00_0_0_0) begin
         errors++; $display("FAIL hijack_vector_fixed obs=%b exp=%b", obs, 10'b011_0_1_00_0_0_0);
      end
      run_instr(4);
      checks++;
      if (obs !== NmiT0) begin
         errors++; $display("FAIL hijack_chain_nmi obs=%b exp=%b", obs, NmiT0);
      end
      run_instr(7);
      checks++;
      if (obs !== Run0) begin
         errors++; $display("FAIL hijack_chain_exit obs=%b exp=%b", obs, Run0);
      end
`endif
      i_nmi_n = 1'b1;
      run_instr(2);
   endtask

   task automatic test_tcu_max_and_reset();
      for (int k = 0; k < 7; k++) tick();
      checks++;
      if (obs !== 10'b111_0_0_00_0_1_0) begin
         errors++; $display("FAIL tcu_max obs=%b exp=%b", obs, 10'b111_0_0_00_0_1_0);
      end
      tick();
      checks++;
      if (obs !== Run0) begin
         errors++; $display("FAIL tcu_wrap obs=%b exp=%b", obs, Run0);
      end
      i_irq_n = 1'b0; i_flag_i = 1'b0;
      run_instr(2);
      i_irq_n = 1'b1; i_flag_i = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      checks++;
      if (obs !== 10'b101_0_1_00_0_0_0) begin
         errors++; $display("FAIL entry_t5 obs=%b exp=%b", obs, 10'b101_0_1_00_0_0_0);
      end
      i_reset = 1'b1;
      tick();
      checks++;
      if (obs !== ResetVal) begin
         errors++; $display("FAIL mid_entry_reset obs=%b exp=%b", obs, ResetVal);
      end
      i_reset = 1'b0;
      run_instr(7);
      checks++;
      if (obs !== Run0) begin
         errors++; $display("FAIL post_reset_exit obs=%b exp=%b", obs, Run0);
      end
   endtask

   initial begin
      i_reset      = 1'b1;
      i_rdy        = 1'b1;
      i_last_cycle = 1'b0;
      i_nmi_n      = 1'b1;
      i_irq_n      = 1'b1;
      i_flag_i     = 1'b1;
      test_reset();
      test_irq();
      test_nmi_level();
      test_nmi_chain();
      test_stall();
      test_hijack();
      test_tcu_max_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Timing and interrupt controller for the CPU core. Owns the timing control unit (TCU) step counter that drives the instruction register and decoder.
- Detects NMI edges and IRQ levels and tracks pending reset.
- At each instruction boundary, decides whether the next opcode fetch is replaced by a forced BRK.
- Supplies the IR force-BRK strobe, vector select, PC-increment hold, B-flag value and write inhibit for the entry sequence.

Parameters:
- TCU_WIDTH, 3, width of the step counter.
- TCU_MAX, 7, highest legal step; reaching it without i_last_cycle forces a boundary.

Ports:
- i_clk  input  1  core clock; all state updates on posedge.
- i_reset  input  1  synchronous, active-high reset.
- i_rdy  input  1  1 = advance this cycle; 0 = stall (hold TCU and sequence state).
- i_last_cycle  input  1  decoder: the current step is the final step of the instruction.
- i_nmi_n  input  1  NMI line, active low, edge-triggered.
- i_irq_n  input  1  IRQ line, active low, level-sensitive.
- i_flag_i  input  1  P register I flag; 1 masks IRQ.
- o_tcu  output  TCU_WIDTH  current step (0 = opcode fetch, IR loads at step 1).
- o_sync  output  1  high when o_tcu==0.
- o_interrupt  output  1  force BRK into IR; held for the whole forced entry.
- o_vector_sel  output  2  00 IRQ/BRK ($FFFE), 01 NMI ($FFFA), 10 RESET ($FFFC).
- o_pc_hold  output  1  inhibit PC increment.
- o_b_flag  output  1  B value to push: 1 for software BRK, 0 for forced entry.
- o_write_inhibit  output  1  suppress bus writes (reset entry pushes become reads).

Behaviour:
- Reset, in any state and at any step, sets:
  - o_tcu=0 and reset_pending=1, so the first fetch after reset is a forced entry.
  - nmi_pending=0 and nmi_prev=1.
  - o_interrupt=1, o_vector_sel=10, o_pc_hold=1, o_b_flag=0, o_write_inhibit=1.
- TCU, when i_rdy=1:
  - If i_last_cycle or o_tcu==TCU_MAX, next o_tcu=0.
  - Otherwise next o_tcu = o_tcu+1.
  - When i_rdy=0, the TCU and all sequence registers hold.
- NMI edge detector:
  - Runs every cycle, including while i_rdy=0.
  - Each cycle nmi_prev <= i_nmi_n.
  - An edge is nmi_prev=1 and i_nmi_n=0; it sets nmi_pending.
  - Holding the line low does not re-trigger.
- IRQ active = !i_irq_n && !i_flag_i, evaluated only at the decision point.
- Decision point: the cycle with i_rdy=1 and a boundary (tcu returning to 0).
  - take = reset_pending | nmi_pending | irq_active.
  - Source priority: reset > NMI > IRQ.
- Sequence state machine:
  - RUN:
    - Outputs o_interrupt=0, o_pc_hold=0, o_write_inhibit=0, o_b_flag=1, o_vector_sel=00.
    - At the decision point, take=1 moves to ENTRY and latches the source into o_vector_sel.
  - ENTRY:
    - Active from the following T0 until the next decision point.
    - o_interrupt=1.
    - o_pc_hold=1 during steps 0 and 1 only.
    - o_b_flag=0.
    - o_write_inhibit=1 only when o_vector_sel=10.
    - At step 1 with i_rdy=1: the serviced source's pending bit clears (reset_pending or nmi_pending).
    - At the next decision point, re-evaluate take: go back to RUN, or chain to ENTRY again.
- Simultaneous events: an NMI edge in the same cycle as the nmi_pending clear leaves nmi_pending=1, so the new edge is serviced later.
- IRQ deasserted before the decision point: not taken; no latching.
- IRQ going away after the decision point: does not abort the entry.
- Outputs are registered except o_sync and o_pc_hold, which decode from o_tcu and state.

Optional Feature:
- Macro: INTERRUPT_SEQUENCER_NMI_HIJACK_EN.
- Defined:
  - Condition: an NMI edge, or nmi_pending, while in ENTRY with o_vector_sel=00 and o_tcu<=4.
  - Response: o_vector_sel switches to 01 on the next cycle and nmi_pending clears. This models 6502 NMI hijack of IRQ/BRK.
- Undefined:
  - o_vector_sel is fixed for the whole entry.
  - The NMI stays pending and is serviced at the next decision point.

Test Plan:
- Reset held 2 cycles, then released with i_rdy=1 and i_last_cycle asserted at tcu=6 -> tcu steps 0..6 then 0. o_interrupt=1, o_vector_sel=10, o_write_inhibit=1 throughout; o_pc_hold=1 at tcu 0,1 only. Next entry is RUN with o_interrupt=0.
- i_irq_n=0, i_flag_i=0 at the decision point -> ENTRY with o_vector_sel=00, o_b_flag=0. With i_flag_i=1 instead -> stays RUN, o_interrupt=0.
- NMI pulse high->low held low 20 cycles -> exactly one entry with vector 01. A second falling edge arriving in the step-1 clear cycle -> second NMI entry follows.
- i_rdy=0 for 3 cycles at tcu=2 with an NMI edge during the stall -> tcu stays 2. nmi_pending=1 after the stall, serviced at the next boundary.
- IRQ entry at tcu=2 plus an NMI edge (macro defined) -> o_vector_sel becomes 01 next cycle, nmi_pending=0. Macro undefined -> vector stays 00, NMI entry chains immediately after.
- tcu reaches 7 without i_last_cycle -> next tcu=0. Reset asserted at tcu=5 mid-ENTRY -> all outputs at reset values on the next cycle.
